// File: rtl/nn_weight_update.sv
// Gradient-consuming weight-update unit: counts ones on per-weight gradient bitstreams
// over 2^WB enabled samples, then applies a shifted, saturating SGD step to each weight.
module nn_weight_update #(
  parameter int NB  = 16,
  parameter int NN  = 3,
  parameter int WB  = 8,
  parameter int LRS = 4
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             start,
  input  logic             en,
  input  logic [NN-1:0]    dalpha,
  input  logic             dbeta,
  input  logic             ld,
  input  logic [NN*NB-1:0] ld_alpha,
  input  logic [NB-1:0]    ld_beta,
  output logic [NN*NB-1:0] alpha,
  output logic [NB-1:0]    beta,
  output logic             busy,
  output logic             upd_valid
);

  localparam int W  = 1 << WB;
  localparam int CW = WB + 1;
  localparam int GW = WB + 2;
  localparam int IW = $clog2(NN + 1);

  localparam logic signed [NB-1:0] W_MAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic signed [NB-1:0] W_MIN = {1'b1, {(NB-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_APPLY, S_DONE} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q [NN];
  logic [CW-1:0]         cntb_q;
  logic [CW-1:0]         samp_q;
  logic [IW-1:0]         idx_q;
  logic signed [NB-1:0]  alpha_q [NN];
  logic signed [NB-1:0]  beta_q;
  logic                  busy_q;
  logic                  upd_valid_q;

  // Shared update datapath: operands are selected by idx_q (idx == NN selects beta).
  logic [CW-1:0]         sel_cnt;
  logic signed [NB-1:0]  sel_w;
  logic signed [GW-1:0]  grad;
  logic signed [GW-1:0]  step;
  logic signed [NB:0]    diff;
  logic signed [NB-1:0]  w_new_d;

  always_comb begin
    sel_cnt = cntb_q;
    sel_w   = beta_q;
    for (int n = 0; n < NN; n++) begin
      if (idx_q == IW'(n)) begin
        sel_cnt = cnt_q[n];
        sel_w   = alpha_q[n];
      end
    end
  end

  // 2*cnt - W wraps correctly in GW bits because the true result lies in [-W, W].
  assign grad = $signed({sel_cnt, 1'b0} - GW'(W));
  assign step = grad >>> LRS;
  assign diff = $signed({sel_w[NB-1], sel_w}) - $signed({{(NB+1-GW){step[GW-1]}}, step});

  always_comb begin
    if (diff[NB] != diff[NB-1]) begin
      w_new_d = diff[NB] ? W_MIN : W_MAX;
    end else begin
      w_new_d = diff[NB-1:0];
    end
  end

  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      state_q     <= S_IDLE;
      cntb_q      <= '0;
      samp_q      <= '0;
      idx_q       <= '0;
      beta_q      <= '0;
      busy_q      <= 1'b0;
      upd_valid_q <= 1'b0;
      for (int n = 0; n < NN; n++) begin
        cnt_q[n]   <= '0;
        alpha_q[n] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          upd_valid_q <= 1'b0;
          if (ld) begin
            beta_q <= ld_beta;
            for (int n = 0; n < NN; n++) begin
              alpha_q[n] <= ld_alpha[n*NB +: NB];
            end
          end
          if (start) begin
            state_q <= S_ACCUM;
            busy_q  <= 1'b1;
            cntb_q  <= '0;
            samp_q  <= '0;
            idx_q   <= '0;
            for (int n = 0; n < NN; n++) begin
              cnt_q[n] <= '0;
            end
          end
        end

        S_ACCUM: begin
          if (en) begin
            cntb_q <= cntb_q + CW'(dbeta);
            samp_q <= samp_q + 1'b1;
            for (int n = 0; n < NN; n++) begin
              cnt_q[n] <= cnt_q[n] + CW'(dalpha[n]);
            end
            if (samp_q == CW'(W - 1)) begin
              state_q <= S_APPLY;
              idx_q   <= '0;
            end
          end
        end

        S_APPLY: begin
          if (idx_q == IW'(NN)) begin
            beta_q      <= w_new_d;
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            upd_valid_q <= 1'b1;
          end else begin
            for (int n = 0; n < NN; n++) begin
              if (idx_q == IW'(n)) begin
                alpha_q[n] <= w_new_d;
              end
            end
            idx_q <= idx_q + 1'b1;
          end
        end

        S_DONE: begin
          upd_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NN; gi++) begin : g_alpha_out
      assign alpha[gi*NB +: NB] = alpha_q[gi];
    end
  endgenerate

  assign beta      = beta_q;
  assign busy      = busy_q;
  assign upd_valid = upd_valid_q;

endmodule

// File: tb/tb_nn_weight_update.sv
// Directed-sequence bench with randomized gradient streams; expected weights come from
// integer counts of the driven bits and a floor-divide/clamp reference of the SGD step.
module tb_nn_weight_update;

  localparam int NB  = 16;
  localparam int NN  = 3;
  localparam int WB  = 8;
  localparam int LRS = 4;
  localparam int W   = 1 << WB;
  localparam int BOUND = 2000;

  logic             CLK = 1'b0;
  logic             INIT = 1'b1;
  logic             start = 1'b0;
  logic             en = 1'b0;
  logic [NN-1:0]    dalpha = '0;
  logic             dbeta = 1'b0;
  logic             ld = 1'b0;
  logic [NN*NB-1:0] ld_alpha = '0;
  logic [NB-1:0]    ld_beta = '0;
  logic [NN*NB-1:0] alpha;
  logic [NB-1:0]    beta;
  logic             busy;
  logic             upd_valid;

  nn_weight_update #(.NB(NB), .NN(NN), .WB(WB), .LRS(LRS)) dut (
    .CLK(CLK), .INIT(INIT), .start(start), .en(en), .dalpha(dalpha), .dbeta(dbeta),
    .ld(ld), .ld_alpha(ld_alpha), .ld_beta(ld_beta),
    .alpha(alpha), .beta(beta), .busy(busy), .upd_valid(upd_valid)
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;
  int m_alpha [NN];
  int m_beta;
  int cnt_a [NN];
  int cnt_b;

  task automatic chk(string tag, int got, int exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int rd_alpha(int n);
    return int'($signed(alpha[n*NB +: NB]));
  endfunction

  function automatic int floor_shift(int g);
    int d = 1 << LRS;
    if (g >= 0) return g / d;
    return -((-g + d - 1) / d);
  endfunction

  function automatic int clampw(int v);
    int hi = (1 << (NB - 1)) - 1;
    int lo = -(1 << (NB - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic check_weights(string tag);
    for (int n = 0; n < NN; n++) begin
      chk($sformatf("%s_alpha%0d", tag, n), rd_alpha(n), m_alpha[n]);
    end
    chk({tag, "_beta"}, int'($signed(beta)), m_beta);
  endtask

  task automatic drive_ld(int a0, int a1, int a2, int b);
    ld_alpha = {16'(a2), 16'(a1), 16'(a0)};
    ld_beta  = 16'(b);
    ld       = 1'b1;
    m_alpha[0] = a0; m_alpha[1] = a1; m_alpha[2] = a2; m_beta = b;
  endtask

  task automatic load_w(string tag, int a0, int a1, int a2, int b);
    drive_ld(a0, a1, a2, b);
    tick();
    ld = 1'b0;
    check_weights(tag);
  endtask

  task automatic garbage_ctrl();
    start    = 1'b1;
    ld       = 1'b1;
    ld_alpha = {$urandom, $urandom};
    ld_beta  = 16'($urandom);
  endtask

  // mode: 0 random, 1 all-ones alpha / zero beta, 2 alternating, 3 dalpha[1] ones for 127 samples,
  // 4 dalpha[0] always one / dbeta zero. enpat: 0 always, 1 every other cycle, 2 random.
  task automatic run_window(string tag, int mode, int enpat, int rst_at, bit junk, bit ldstart);
    int samples = 0;
    int gaps = 0;
    int cyc;
    bit e;
    logic [NN-1:0] da;
    logic db;
    for (int n = 0; n < NN; n++) cnt_a[n] = 0;
    cnt_b = 0;
    if (ldstart) begin
      drive_ld($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
               $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    ld    = 1'b0;
    cyc   = 1;
    chk({tag, "_busy_start"}, int'(busy), 1);
    while (samples < W) begin
      if (rst_at >= 0 && samples == rst_at) begin
        INIT = 1'b0;
        #1;
        chk({tag, "_rst_alpha"}, int'(alpha), 0);
        chk({tag, "_rst_beta"}, int'(beta), 0);
        chk({tag, "_rst_busy"}, int'(busy), 0);
        chk({tag, "_rst_upd"}, int'(upd_valid), 0);
        #1;
        INIT = 1'b1;
        en = 1'b0;
        for (int n = 0; n < NN; n++) m_alpha[n] = 0;
        m_beta = 0;
        $display("txn %s: reset after %0d samples", tag, samples);
        return;
      end
      if (enpat == 0) e = 1'b1;
      else if (enpat == 1) e = (cyc % 2 == 1);
      else e = ($urandom_range(0, 3) != 0);
      da = NN'($urandom);
      db = 1'($urandom);
      if (e) begin
        case (mode)
          1: begin da = '1; db = 1'b0; end
          2: begin da = (samples % 2 == 0) ? '1 : '0; db = (samples % 2 == 0); end
          3: da[1] = (samples < 127);
          4: begin da[0] = 1'b1; db = 1'b0; end
          default: ;
        endcase
        for (int n = 0; n < NN; n++) cnt_a[n] += int'(da[n]);
        cnt_b += int'(db);
      end
      en = e; dalpha = da; dbeta = db;
      if (junk && cyc == 50) garbage_ctrl();
      tick();
      start = 1'b0;
      ld    = 1'b0;
      cyc++;
      if (e) samples++; else gaps++;
    end
    en = 1'b0;
    while (!upd_valid && cyc < BOUND) begin
      if (junk && cyc == W + gaps + 1) garbage_ctrl();
      dalpha = NN'($urandom);
      dbeta  = 1'($urandom);
      tick();
      start = 1'b0;
      ld    = 1'b0;
      cyc++;
    end
    for (int n = 0; n < NN; n++) m_alpha[n] = clampw(m_alpha[n] - floor_shift(2 * cnt_a[n] - W));
    m_beta = clampw(m_beta - floor_shift(2 * cnt_b - W));
    chk({tag, "_latency"}, cyc, W + gaps + NN + 2);
    chk({tag, "_upd_valid"}, int'(upd_valid), 1);
    chk({tag, "_busy_done"}, int'(busy), 0);
    check_weights(tag);
    tick();
    chk({tag, "_upd_pulse_end"}, int'(upd_valid), 0);
    $display("txn %s: gaps=%0d latency=%0d alpha=%0d,%0d,%0d beta=%0d", tag, gaps, cyc,
             m_alpha[0], m_alpha[1], m_alpha[2], m_beta);
  endtask

  initial begin
    for (int n = 0; n < NN; n++) m_alpha[n] = 0;
    m_beta = 0;
    #3;
    INIT = 1'b0;
    #1;
    chk("reset_alpha", int'(alpha), 0);
    chk("reset_beta", int'(beta), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_upd", int'(upd_valid), 0);
    tick();
    tick();
    INIT = 1'b1;
    tick();
    $display("txn reset: outputs cleared");

    run_window("full_pos", 1, 0, -1, 1'b0, 1'b0);

    load_w("load_zero", 100, -200, 300, 7);
    run_window("zero_grad", 2, 0, -1, 1'b0, 1'b0);

    load_w("load_sat", -32760, $urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000, 32760);
    run_window("saturate", 4, 0, -1, 1'b0, 1'b0);

    load_w("load_round", 11, 22, -33, 44);
    run_window("en_gaps", 3, 1, -1, 1'b0, 1'b0);

    run_window("rst_mid", 0, 0, 100, 1'b0, 1'b0);
    tick();
    run_window("after_rst", 0, 0, -1, 1'b0, 1'b0);

    run_window("ignored_ctrl", 0, 2, -1, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      run_window($sformatf("rand%0d", i), 0, 2, -1, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
